fetch_mem_bridge: RTL and testbench

Sits directly downstream of the fetch stage and upstream of the wavepool. Accepts per-wave instruction read requests (`buff_rd_en`/`buff_addr`/`buff_tag`) and queues them in a circular tag buffer. It issues them in order to instruction memory over a valid/ready handshake, matches in-order memory responses back to their tags, and delivers PC, wave ID and instruction to the wavepool with a `buff_ack` pulse. The fetch stage has no stall input, so the bridge must always accept; overflow is reported, not back-pressured.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_tag_ring.sv | 69 ++++++
 rtl/fetch_mem_bridge.sv | 130 +++++++++++++
 tb/tb_fetch_mem_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-to-memory bridge: the layout of the
// 39-bit fetch tag and helpers that pull its fields apart.
package fetch_pkg;

   localparam int TAG_W       = 39;
   localparam int WFID_W      = 6;
   localparam int PC_W        = 32;

   localparam int TAG_FIRST   = 38;
   localparam int TAG_WFID_HI = 37;
   localparam int TAG_WFID_LO = 32;
   localparam int TAG_PC_HI   = 31;
   localparam int TAG_PC_LO   = 0;

   function automatic logic [PC_W-1:0] tag_pc(input logic [TAG_W-1:0] tag);
      return tag[TAG_PC_HI:TAG_PC_LO];
   endfunction

   function automatic logic [WFID_W-1:0] tag_wfid(input logic [TAG_W-1:0] tag);
      return tag[TAG_WFID_HI:TAG_WFID_LO];
   endfunction

   function automatic logic tag_first(input logic [TAG_W-1:0] tag);
      return tag[TAG_FIRST];
   endfunction

endpackage

// File: rtl/fetch_tag_ring.sv
// Circular tag buffer with three pointers: write (enqueue), issue (sent to
// memory) and response (returned from memory). Each pointer carries one wrap
// bit so full and empty regions can be told apart. The pointers always satisfy
// rsp_ptr <= iss_ptr <= wr_ptr modulo the wrap.
module fetch_tag_ring
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             iss_adv,
   input  logic             rsp_adv,
   output logic [TAG_W-1:0] iss_tag,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             full,
   output logic             pending,
   output logic             outstanding
);

   localparam int             PW      = $clog2(DEPTH);
   localparam logic [PW:0]    PTR_INC = (PW+1)'(1);
   localparam logic [PW:0]    PTR_CAP = (PW+1)'(DEPTH);

   logic [TAG_W-1:0] tags [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      iss_ptr;
   logic [PW:0]      rsp_ptr;
   logic [PW:0]      fill;

   // Occupancy counts everything not yet answered by memory, issued or not.
   always_comb begin
      fill        = wr_ptr - rsp_ptr;
      full        = (fill == PTR_CAP);
      pending     = (wr_ptr != iss_ptr);
      outstanding = (iss_ptr != rsp_ptr);
      iss_tag     = tags[iss_ptr[PW-1:0]];
      rsp_tag     = tags[rsp_ptr[PW-1:0]];
   end

   // Tag storage carries no reset; pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_ptr[PW-1:0]] <= wr_tag;
      end
   end

   // The three pointers advance independently; callers guarantee ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         iss_ptr <= '0;
         rsp_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (iss_adv) begin
            iss_ptr <= iss_ptr + PTR_INC;
         end
         if (rsp_adv) begin
            rsp_ptr <= rsp_ptr + PTR_INC;
         end
      end
   end

endmodule

// File: rtl/fetch_mem_bridge.sv
// Bridge between the fetch stage and instruction memory. Requests are always
// accepted into a tag ring (overflow is flagged, never back-pressured), issued
// in order over valid/ready, and in-order responses are paired with their tags
// and delivered to the wavepool one cycle later.
// Optional feature: define FETCH_MEM_BYPASS_EN to let a request into an empty
// buffer go straight to memory in the same cycle.
module fetch_mem_bridge
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              buff_rd_en,
   input  logic [31:0]       buff_addr,
   input  logic [TAG_W-1:0]  buff_tag,
   output logic              buff_ack,
   output logic              mem_rd_en,
   output logic [31:0]       mem_addr,
   input  logic              mem_ready,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_data,
   output logic              fetch2wave_valid,
   output logic [WFID_W-1:0] fetch2wave_wfid,
   output logic [31:0]       fetch2wave_pc,
   output logic              fetch2wave_first,
   output logic [31:0]       fetch2wave_instr,
   output logic              fetch_overflow_err,
   output logic              fetch_rsp_err
);

   logic             wr_en;
   logic             iss_adv;
   logic             rsp_adv;
   logic [TAG_W-1:0] iss_tag;
   logic [TAG_W-1:0] rsp_tag;
   logic             full;
   logic             pending;
   logic             outstanding;

   fetch_tag_ring #(
      .DEPTH(DEPTH)
   ) u_ring (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_tag     (buff_tag),
      .iss_adv    (iss_adv),
      .rsp_adv    (rsp_adv),
      .iss_tag    (iss_tag),
      .rsp_tag    (rsp_tag),
      .full       (full),
      .pending    (pending),
      .outstanding(outstanding)
   );

   // Full is judged on pre-edge pointers, so a response freeing a slot this
   // cycle does not rescue a request arriving while full.
   always_comb begin
      wr_en   = buff_rd_en & ~full;
      rsp_adv = mem_rsp_valid & outstanding;
   end

`ifdef FETCH_MEM_BYPASS_EN
   logic bypass;

   // An empty buffer forwards the incoming request directly; the entry is still
   // written, and if memory takes it the issue pointer moves past it together
   // with the write pointer.
   always_comb begin
      bypass    = ~pending & wr_en;
      mem_rd_en = pending | bypass;
      mem_addr  = '0;
      if (pending) begin
         mem_addr = tag_pc(iss_tag);
      end else if (bypass) begin
         mem_addr = buff_addr;
      end
      iss_adv   = mem_rd_en & mem_ready;
   end
`else
   logic unused_buff_addr;

   // Issue only from stored entries; the address is the PC inside the tag, so
   // the separate buff_addr copy is not needed here.
   always_comb begin
      unused_buff_addr = ^buff_addr;
      mem_rd_en        = pending;
      mem_addr         = pending ? tag_pc(iss_tag) : '0;
      iss_adv          = mem_rd_en & mem_ready;
   end
`endif

   // Delivery registers: pulse once per matched response, hold data otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buff_ack         <= 1'b0;
         fetch2wave_valid <= 1'b0;
         fetch2wave_wfid  <= '0;
         fetch2wave_pc    <= '0;
         fetch2wave_first <= 1'b0;
         fetch2wave_instr <= '0;
      end else begin
         buff_ack         <= rsp_adv;
         fetch2wave_valid <= rsp_adv;
         if (rsp_adv) begin
            fetch2wave_wfid  <= tag_wfid(rsp_tag);
            fetch2wave_pc    <= tag_pc(rsp_tag);
            fetch2wave_first <= tag_first(rsp_tag);
            fetch2wave_instr <= mem_rsp_data;
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_overflow_err <= 1'b0;
         fetch_rsp_err      <= 1'b0;
      end else begin
         if (buff_rd_en & full) begin
            fetch_overflow_err <= 1'b1;
         end
         if (mem_rsp_valid & ~outstanding) begin
            fetch_rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_mem_bridge.sv
// Directed self-checking bench for fetch_mem_bridge with DEPTH=4. Inputs are
// driven 1ns after the rising edge; outputs are sampled at the same point.
// Bypass-dependent expectations follow FETCH_MEM_BYPASS_EN.
module tb_fetch_mem_bridge;

   logic        clk;
   logic        rst;
   logic        buff_rd_en;
   logic [31:0] buff_addr;
   logic [38:0] buff_tag;
   logic        buff_ack;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        fetch2wave_valid;
   logic [5:0]  fetch2wave_wfid;
   logic [31:0] fetch2wave_pc;
   logic        fetch2wave_first;
   logic [31:0] fetch2wave_instr;
   logic        fetch_overflow_err;
   logic        fetch_rsp_err;

   int errors = 0;
   int checks = 0;

`ifdef FETCH_MEM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   fetch_mem_bridge #(
      .DEPTH(4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .buff_rd_en        (buff_rd_en),
      .buff_addr         (buff_addr),
      .buff_tag          (buff_tag),
      .buff_ack          (buff_ack),
      .mem_rd_en         (mem_rd_en),
      .mem_addr          (mem_addr),
      .mem_ready         (mem_ready),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_data      (mem_rsp_data),
      .fetch2wave_valid  (fetch2wave_valid),
      .fetch2wave_wfid   (fetch2wave_wfid),
      .fetch2wave_pc     (fetch2wave_pc),
      .fetch2wave_first  (fetch2wave_first),
      .fetch2wave_instr  (fetch2wave_instr),
      .fetch_overflow_err(fetch_overflow_err),
      .fetch_rsp_err     (fetch_rsp_err)
   );

   // 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [38:0] mk_tag(input bit first, input int wfid, input logic [31:0] pc);
      return {first, 6'(wfid), pc};
   endfunction

   task automatic applyStimulus(input logic rd_en, input logic [38:0] tag, input logic ready,
                                input logic rsp_valid, input logic [31:0] rsp_data);
      buff_rd_en    = rd_en;
      buff_tag      = tag;
      buff_addr     = tag[31:0];
      mem_ready     = ready;
      mem_rsp_valid = rsp_valid;
      mem_rsp_data  = rsp_data;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
      end
   endtask

   task automatic checkDelivery(input string name, input int wfid, input logic [31:0] pc,
                                input logic first, input logic [31:0] instr);
      checkOutput({name, "_valid"}, 32'(fetch2wave_valid), 32'd1);
      checkOutput({name, "_ack"},   32'(buff_ack),         32'd1);
      checkOutput({name, "_wfid"},  32'(fetch2wave_wfid),  32'(wfid));
      checkOutput({name, "_pc"},    fetch2wave_pc,         pc);
      checkOutput({name, "_first"}, 32'(fetch2wave_first), 32'(first));
      checkOutput({name, "_instr"}, fetch2wave_instr,      instr);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      tick();
      tick();
      checkOutput("rst_ack",     32'(buff_ack),           32'd0);
      checkOutput("rst_rd_en",   32'(mem_rd_en),          32'd0);
      checkOutput("rst_addr",    mem_addr,                32'd0);
      checkOutput("rst_valid",   32'(fetch2wave_valid),   32'd0);
      checkOutput("rst_pc",      fetch2wave_pc,           32'd0);
      checkOutput("rst_instr",   fetch2wave_instr,        32'd0);
      checkOutput("rst_ovf",     32'(fetch_overflow_err), 32'd0);
      checkOutput("rst_rsperr",  32'(fetch_rsp_err),      32'd0);
      rst = 1'b0;
      tick();

      // Single request, response two cycles after the request
      $display("[TB] single request");
      applyStimulus(1'b1, mk_tag(1'b1, 5, 32'h100), 1'b1, 1'b0, '0);
      checkOutput("t1_c0_rd_en", 32'(mem_rd_en), BYPASS ? 32'd1 : 32'd0);
      checkOutput("t1_c0_addr",  mem_addr,       BYPASS ? 32'h100 : 32'h0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      checkOutput("t1_c1_rd_en", 32'(mem_rd_en), BYPASS ? 32'd0 : 32'd1);
      checkOutput("t1_c1_addr",  mem_addr,       BYPASS ? 32'h0 : 32'h100);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hBF810000);
      checkOutput("t1_c2_rd_en", 32'(mem_rd_en), 32'd0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkDelivery("t1_dlv", 5, 32'h100, 1'b1, 32'hBF810000);
      tick();
      checkOutput("t1_ack_drop", 32'(buff_ack),  32'd0);
      checkOutput("t1_pc_hold",  fetch2wave_pc,  32'h100);

      // Fill to capacity, then overflow
      $display("[TB] fill and overflow");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, mk_tag(1'b0, i, 32'h200 + 32'(4 * i)), 1'b0, 1'b0, '0);
         tick();
      end
      checkOutput("t2_ovf_before", 32'(fetch_overflow_err), 32'd0);
      applyStimulus(1'b1, mk_tag(1'b0, 4, 32'h300), 1'b0, 1'b0, '0);
      tick();
      checkOutput("t2_ovf_after", 32'(fetch_overflow_err), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
         checkOutput($sformatf("t2_iss%0d_en", i),   32'(mem_rd_en), 32'd1);
         checkOutput($sformatf("t2_iss%0d_addr", i), mem_addr,       32'h200 + 32'(4 * i));
         tick();
      end
      checkOutput("t2_drained", 32'(mem_rd_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hA0000000 + 32'(i));
         tick();
         checkDelivery($sformatf("t2_dlv%0d", i), i, 32'h200 + 32'(4 * i), 1'b0, 32'hA0000000 + 32'(i));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("t2_valid_drop", 32'(fetch2wave_valid), 32'd0);

      // Toggling ready: each address held until accepted
      $display("[TB] toggling ready");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, mk_tag(1'b0, 10 + i, 32'h400 + 32'(4 * i)), 1'b0, 1'b0, '0);
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, '0, (k % 2) == 1, 1'b0, '0);
         checkOutput($sformatf("t3_k%0d_en", k),   32'(mem_rd_en), 32'd1);
         checkOutput($sformatf("t3_k%0d_addr", k), mem_addr,       32'h400 + 32'(4 * (k / 2)));
         tick();
      end
      checkOutput("t3_drained", 32'(mem_rd_en), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hC0000000 + 32'(i));
         tick();
         checkDelivery($sformatf("t3_dlv%0d", i), 10 + i, 32'h400 + 32'(4 * i), 1'b0, 32'hC0000000 + 32'(i));
      end

      // Spurious response with nothing outstanding
      $display("[TB] spurious response");
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("t4_valid",  32'(fetch2wave_valid), 32'd0);
      checkOutput("t4_ack",    32'(buff_ack),         32'd0);
      checkOutput("t4_rsperr", 32'(fetch_rsp_err),    32'd1);
      checkOutput("t4_instr",  fetch2wave_instr,      32'hC0000002);
      checkOutput("t4_rd_en",  32'(mem_rd_en),        32'd0);

      // Wrap-around: 20 sequential requests
      $display("[TB] wrap-around");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, mk_tag(1'b0, i, 32'h1000 + 32'(4 * i)), 1'b1, 1'b0, '0);
         tick();
         applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
         checkOutput($sformatf("t5_%0d_en", i), 32'(mem_rd_en), BYPASS ? 32'd0 : 32'd1);
         tick();
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h50000000 + 32'(i));
         tick();
         checkDelivery($sformatf("t5_dlv%0d", i), i, 32'h1000 + 32'(4 * i), 1'b0, 32'h50000000 + 32'(i));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      tick();

      // Reset with two requests in flight
      $display("[TB] reset with outstanding requests");
      applyStimulus(1'b1, mk_tag(1'b0, 20, 32'h2000), 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b1, mk_tag(1'b0, 21, 32'h2004), 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("t6_rd_en",  32'(mem_rd_en),          32'd0);
      checkOutput("t6_pc",     fetch2wave_pc,           32'd0);
      checkOutput("t6_wfid",   32'(fetch2wave_wfid),    32'd0);
      checkOutput("t6_instr",  fetch2wave_instr,        32'd0);
      checkOutput("t6_ovf",    32'(fetch_overflow_err), 32'd0);
      checkOutput("t6_rsperr", 32'(fetch_rsp_err),      32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(1'b1, mk_tag(1'b1, 33, 32'h5000), 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, '0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h12345678);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
      checkDelivery("t6_dlv", 33, 32'h5000, 1'b1, 32'h12345678);
      checkOutput("t6_rsperr_after", 32'(fetch_rsp_err), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
